kernel_rr_dispatcher: RTL and testbench
=======================================

Name: kernel_rr_dispatcher

Overview:
- Sits between the job manager's descriptor output (first-word fall-through (FWFT) queue) and the KERNEL_NUM processing engines.
- Dispatches each descriptor to an idle engine in round-robin order and tracks per-engine occupancy.
- Collects engine completions and serialises them as completion records into the job-completion writer.
- Owns the engine_start/jd_payload/engine_done handshake end to end.

Parameters:
- KERNEL_NUM, 2, number of engines (1..16).
- DSC_WIDTH, 1024, descriptor/payload width in bits.
- TAG_LSB, 0, lowest bit of the 32-bit job tag inside the descriptor.

Ports:
- clk  in  1  the single clock.
- rst  in  1  synchronous, active-high reset.
- enable_i  in  1  dispatch enable; low blocks new dispatches only.
- dsc_ready_i  in  1  head descriptor valid (FWFT).
- dsc_data_i  in  DSC_WIDTH  head descriptor.
- dsc_pull_o  out  1  pop strobe, one per dispatched descriptor.
- engine_start_o  out  KERNEL_NUM  one-hot, 1-cycle start pulse.
- jd_payload_o  out  DSC_WIDTH  descriptor for the started engine; valid while start is high.
- engine_done_i  in  KERNEL_NUM  1-cycle done pulse per engine.
- engine_status_i  in  KERNEL_NUM  error flag, sampled with the matching done bit.
- complete_ready_i  in  1  completion writer can accept a record.
- complete_push_o  out  1  1-cycle record strobe.
- return_data_o  out  41  record: [40:33] engine index, [32] status, [31:0] job tag.
- busy_o  out  1  any engine not IDLE.
- spurious_o  out  1  sticky: done seen on an IDLE engine.

Behaviour:
- Per-engine state: IDLE -> RUN on dispatch; RUN -> PEND on done; PEND -> IDLE on record push.
- Dispatch condition in cycle T: enable_i & dsc_ready_i & at least one IDLE engine.
- dsc_pull_o is combinational and high in T.
- Grant: round-robin from the last granted index + 1; after reset the pointer starts at engine 0.
- In T+1, registered: engine_start_o[g]=1 and jd_payload_o=dsc_data_i captured at T.
- Tag register[g] <= dsc_data_i[TAG_LSB+31:TAG_LSB] at T.
- Throughput: at most one dispatch per cycle.
- The upstream queue must reflect the pop in dsc_ready_i/dsc_data_i at T+1.
- jd_payload_o holds its last value when no start is asserted.
- Done on a RUN engine latches status and moves it to PEND.
- Simultaneous done pulses on several engines are all latched in the same cycle.
- Done on an IDLE or PEND engine: ignored, and spurious_o sets until rst.
- Completion arbitration: round-robin over PEND engines with its own pointer.
- When complete_ready_i=1 and any engine is PEND, in cycle C:
  - complete_push_o=1 and return_data_o={idx, status, tag}, both registered and visible in C+1;
  - the engine returns to IDLE at C+1.
- At most one record per cycle.
- An engine freed at C+1 is eligible for dispatch from C+1.
- A done pulse and a dispatch can never target the same engine in one cycle: dispatch needs IDLE, done needs RUN.
- enable_i low mid-stream: in-flight jobs still complete and report; no pull.
- complete_ready_i low: PEND engines wait indefinitely; dispatch continues to the remaining IDLE engines.
- Reset values: all engines IDLE, both pointers 0, all outputs 0 (jd_payload_o=0, spurious_o=0).
- Reset mid-job discards in-flight state and emits no records; the engines must be reset by the same rst.
- busy_o is registered, derived from next-state: high at T+1 after a dispatch at T.

Decomposition:
- Package jm_sched_pkg:
  - engine state enum (IDLE/RUN/PEND);
  - record field offsets (IDX_MSB=40, IDX_LSB=33, STAT_BIT=32, TAG_MSB=31);
  - record width constant 41.
- Sub-module rr_arbiter #(N):
  - ports: req[N-1:0], advance, grant one-hot;
  - pointer is updated on advance;
  - instantiated twice (dispatch and completion).

Test Plan:
- Reset, then 4 descriptors with tags 0x11..0x14 and KERNEL_NUM=2, engines done 10 cycles after start -> engine order 0,1,0,1; records (0,0,0x11), (1,0,0x12), (0,0,0x13), (1,0,0x14); exactly 4 pulls.
- Both engines assert done in the same cycle, status 1 on engine 1 -> two records on consecutive cycles, engine 0 first, second record [32]=1.
- complete_ready_i held low for 20 cycles with both engines PEND -> no push, dsc_pull_o stays 0 while dsc_ready_i=1; on release, pushes come back-to-back.
- enable_i drops right after the first dispatch with 3 descriptors queued -> exactly 1 pull, 1 record; busy_o returns to 0.
- Done pulse on idle engine 1 -> spurious_o=1 and stays set, no record.
- rst asserted while both engines RUN -> next cycle all outputs 0, busy_o=0; a subsequent descriptor goes to engine 0.

Source files
------------

// File: rtl/jm_sched_pkg.sv
// Shared types and completion-record layout for the kernel round-robin dispatcher.
package jm_sched_pkg;

    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_RUN  = 2'd1,
        ENG_PEND = 2'd2
    } eng_state_e;

    localparam int REC_WIDTH = 41;
    localparam int IDX_MSB   = 40;
    localparam int IDX_LSB   = 33;
    localparam int STAT_BIT  = 32;
    localparam int TAG_MSB   = 31;
    localparam int TAG_WIDTH = TAG_MSB + 1;
    localparam int IDX_WIDTH = IDX_MSB - IDX_LSB + 1;

    // Engine count never exceeds 16, so a fixed-width one-hot input covers every configuration.
    function automatic logic [IDX_WIDTH-1:0] onehot_to_idx(input logic [15:0] onehot);
        logic [IDX_WIDTH-1:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (onehot[i]) idx = IDX_WIDTH'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority starts just after the last granted requester.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win_idx;
    logic          found;
    int            pos;

    // NOTE: every output of a combinational block gets a default before any branch,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        grant   = '0;
        win_idx = ptr_q;
        found   = 1'b0;
        pos     = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr_q) + i;
            if (pos >= N) pos = pos - N;
            if (!found && req[pos]) begin
                grant[pos] = 1'b1;
                win_idx    = PW'(pos);
                found      = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (int'(win_idx) == N - 1) ? '0 : win_idx + PW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/kernel_rr_dispatcher.sv
// Dispatches FWFT descriptors round-robin to idle engines and serialises
// engine completions into 41-bit completion records.
module kernel_rr_dispatcher
    import jm_sched_pkg::*;
#(
    parameter int KERNEL_NUM = 2,
    parameter int DSC_WIDTH  = 1024,
    parameter int TAG_LSB    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  dsc_ready_i,
    input  logic [DSC_WIDTH-1:0]  dsc_data_i,
    output logic                  dsc_pull_o,
    output logic [KERNEL_NUM-1:0] engine_start_o,
    output logic [DSC_WIDTH-1:0]  jd_payload_o,
    input  logic [KERNEL_NUM-1:0] engine_done_i,
    input  logic [KERNEL_NUM-1:0] engine_status_i,
    input  logic                  complete_ready_i,
    output logic                  complete_push_o,
    output logic [40:0]           return_data_o,
    output logic                  busy_o,
    output logic                  spurious_o
);

    eng_state_e              state_q [KERNEL_NUM];
    eng_state_e              state_d [KERNEL_NUM];
    logic [KERNEL_NUM-1:0]   status_q, status_d;
    logic [TAG_WIDTH-1:0]    tag_q [KERNEL_NUM];
    logic [TAG_WIDTH-1:0]    tag_d [KERNEL_NUM];

    logic [KERNEL_NUM-1:0]   idle_vec, pend_vec;
    logic [KERNEL_NUM-1:0]   disp_grant, cmpl_grant;
    logic                    dispatch, complete;
    logic [IDX_WIDTH-1:0]    cmpl_idx;

    logic [KERNEL_NUM-1:0]   start_q, start_d;
    logic [DSC_WIDTH-1:0]    payload_q, payload_d;
    logic                    push_q, push_d;
    logic [REC_WIDTH-1:0]    rec_q, rec_d;
    logic                    busy_q, busy_d;
    logic                    spurious_q, spurious_d;

    always_comb begin
        idle_vec = '0;
        pend_vec = '0;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            idle_vec[k] = (state_q[k] == ENG_IDLE);
            pend_vec[k] = (state_q[k] == ENG_PEND);
        end
    end

    // Pull is combinational, so it is masked during reset to keep the queue untouched.
    assign dispatch = !rst && enable_i && dsc_ready_i && (|idle_vec);
    assign complete = complete_ready_i && (|pend_vec);
    assign cmpl_idx = onehot_to_idx(16'(cmpl_grant));

    rr_arbiter #(.N(KERNEL_NUM)) u_disp_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (idle_vec),
        .advance (dispatch),
        .grant   (disp_grant)
    );

    rr_arbiter #(.N(KERNEL_NUM)) u_cmpl_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (pend_vec),
        .advance (complete),
        .grant   (cmpl_grant)
    );

    always_comb begin
        spurious_d = spurious_q;
        status_d   = status_q;
        tag_d      = tag_q;
        busy_d     = 1'b0;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                ENG_IDLE: if (dispatch && disp_grant[k]) state_d[k] = ENG_RUN;
                ENG_RUN: begin
                    if (engine_done_i[k]) begin
                        state_d[k]  = ENG_PEND;
                        status_d[k] = engine_status_i[k];
                    end
                end
                ENG_PEND: if (complete && cmpl_grant[k]) state_d[k] = ENG_IDLE;
                default:  state_d[k] = ENG_IDLE;
            endcase
            // A done pulse only means something while the engine is running.
            if (engine_done_i[k] && state_q[k] != ENG_RUN) spurious_d = 1'b1;
            if (dispatch && disp_grant[k]) tag_d[k] = dsc_data_i[TAG_LSB +: TAG_WIDTH];
            if (state_d[k] != ENG_IDLE) busy_d = 1'b1;
        end
    end

    always_comb begin
        start_d   = dispatch ? disp_grant : '0;
        payload_d = dispatch ? dsc_data_i : payload_q;
        push_d    = complete;
        rec_d     = rec_q;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            if (complete && cmpl_grant[k]) rec_d = {cmpl_idx, status_q[k], tag_q[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= '{default: ENG_IDLE};
            status_q   <= '0;
            start_q    <= '0;
            payload_q  <= '0;
            push_q     <= '0;
            rec_q      <= '0;
            busy_q     <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            start_q    <= start_d;
            payload_q  <= payload_d;
            push_q     <= push_d;
            rec_q      <= rec_d;
            busy_q     <= busy_d;
            spurious_q <= spurious_d;
        end
    end

    // NOTE: the tag store is left unreset on purpose; a tag is always written on
    // dispatch before its engine can leave IDLE, so its reset value is never read.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

    assign dsc_pull_o      = dispatch;
    assign engine_start_o  = start_q;
    assign jd_payload_o    = payload_q;
    assign complete_push_o = push_q;
    assign return_data_o   = rec_q;
    assign busy_o          = busy_q;
    assign spurious_o      = spurious_q;

endmodule

// File: tb/tb_kernel_rr_dispatcher.sv
// Scoreboard bench for kernel_rr_dispatcher: directed descriptor streams, an
// FWFT queue model, auto-completing engine models and a negedge monitor.
module tb_kernel_rr_dispatcher;

    localparam int K  = 2;
    localparam int DW = 64;
    localparam int TL = 0;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_i;
    logic          dsc_ready_i;
    logic [DW-1:0] dsc_data_i;
    logic          dsc_pull_o;
    logic [K-1:0]  engine_start_o;
    logic [DW-1:0] jd_payload_o;
    logic [K-1:0]  engine_done_i;
    logic [K-1:0]  engine_status_i;
    logic          complete_ready_i;
    logic          complete_push_o;
    logic [40:0]   return_data_o;
    logic          busy_o;
    logic          spurious_o;

    always #5 clk = ~clk;

    kernel_rr_dispatcher #(.KERNEL_NUM(K), .DSC_WIDTH(DW), .TAG_LSB(TL)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable_i         (enable_i),
        .dsc_ready_i      (dsc_ready_i),
        .dsc_data_i       (dsc_data_i),
        .dsc_pull_o       (dsc_pull_o),
        .engine_start_o   (engine_start_o),
        .jd_payload_o     (jd_payload_o),
        .engine_done_i    (engine_done_i),
        .engine_status_i  (engine_status_i),
        .complete_ready_i (complete_ready_i),
        .complete_push_o  (complete_push_o),
        .return_data_o    (return_data_o),
        .busy_o           (busy_o),
        .spurious_o       (spurious_o)
    );

    typedef struct {
        int            eng;
        logic [DW-1:0] payload;
    } start_t;

    start_t        exp_start[$];
    logic [40:0]   exp_rec[$];
    logic [DW-1:0] fifo[$];
    int            push_cyc[$];

    int checks = 0;
    int errors = 0;
    int pulls  = 0;
    int pushes = 0;
    int cyc    = 0;

    int           delay  [K];
    logic         st_cfg [K];
    int           cnt    [K];
    logic [K-1:0] inject;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // eng < 0: descriptor is queued but must not be dispatched.
    task automatic push_desc(input logic [31:0] tag, input int eng);
        logic [DW-1:0] d;
        d = {~tag, tag};
        fifo.push_back(d);
        if (eng >= 0) exp_start.push_back('{eng, d});
    endtask

    task automatic exp_record(input int eng, input logic st, input logic [31:0] tag);
        exp_rec.push_back({8'(eng), st, tag});
    endtask

    task automatic wait_drain(input int budget);
        int left;
        left = budget;
        while ((exp_start.size() != 0 || exp_rec.size() != 0) && left > 0) begin
            tick(1);
            left--;
        end
        check("drain_timeout", 64'(exp_start.size() + exp_rec.size()), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_start"},    64'(engine_start_o), 0);
        check({tag, "_payload"},  jd_payload_o, 0);
        check({tag, "_push"},     64'(complete_push_o), 0);
        check({tag, "_record"},   64'(return_data_o), 0);
        check({tag, "_busy"},     64'(busy_o), 0);
        check({tag, "_spurious"}, 64'(spurious_o), 0);
        check({tag, "_pull"},     64'(dsc_pull_o), 0);
    endtask

    always @(posedge clk) cyc++;

    // FWFT upstream queue: pops one entry after each observed pull.
    logic pull_seen;
    initial begin
        dsc_ready_i = 1'b0;
        dsc_data_i  = '0;
        forever begin
            @(negedge clk);
            pull_seen = dsc_pull_o;
            @(posedge clk);
            #1;
            if (pull_seen && fifo.size() > 0) void'(fifo.pop_front());
            dsc_ready_i = (fifo.size() > 0);
            dsc_data_i  = (fifo.size() > 0) ? fifo[0] : '0;
        end
    end

    // Engine models: done pulse delay[k] cycles after the start pulse.
    initial begin
        engine_done_i   = '0;
        engine_status_i = '0;
        for (int k = 0; k < K; k++) cnt[k] = 0;
        forever begin
            @(posedge clk);
            #1;
            engine_done_i   = '0;
            engine_status_i = '0;
            for (int k = 0; k < K; k++) begin
                if (rst) begin
                    cnt[k] = 0;
                end else begin
                    if (cnt[k] > 0) begin
                        cnt[k]--;
                        if (cnt[k] == 0) begin
                            engine_done_i[k]   = 1'b1;
                            engine_status_i[k] = st_cfg[k];
                        end
                    end
                    if (engine_start_o[k]) cnt[k] = delay[k];
                end
            end
            if (inject != '0) begin
                engine_done_i = engine_done_i | inject;
                inject        = '0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a start or a record.
    start_t        mon_s;
    logic [40:0]   mon_r;
    logic [DW-1:0] last_payload;
    always @(negedge clk) begin
        if (rst) begin
            last_payload = '0;
        end else begin
            if (dsc_pull_o) pulls++;
            if (engine_start_o != '0) begin
                if (exp_start.size() == 0) begin
                    check("unexpected_start", 64'(engine_start_o), 0);
                end else begin
                    mon_s = exp_start.pop_front();
                    check("start_engine", 64'(engine_start_o), 64'(1) << mon_s.eng);
                    check("start_payload", jd_payload_o, mon_s.payload);
                    last_payload = mon_s.payload;
                end
            end else begin
                check("payload_hold", jd_payload_o, last_payload);
            end
            if (complete_push_o) begin
                pushes++;
                push_cyc.push_back(cyc);
                if (exp_rec.size() == 0) begin
                    check("unexpected_record", 64'(return_data_o), 0);
                end else begin
                    mon_r = exp_rec.pop_front();
                    check("record", 64'(return_data_o), 64'(mon_r));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int p0;
    int n0;
    int left;
    initial begin
        rst              = 1'b1;
        enable_i         = 1'b0;
        complete_ready_i = 1'b0;
        inject           = '0;
        for (int k = 0; k < K; k++) begin
            delay[k]  = 10;
            st_cfg[k] = 1'b0;
        end
        tick(3);
        check_zero("reset");
        rst = 1'b0;
        tick(1);

        // Four descriptors alternate across the two engines.
        enable_i         = 1'b1;
        complete_ready_i = 1'b1;
        p0 = pulls;
        push_desc(32'h11, 0);
        push_desc(32'h12, 1);
        push_desc(32'h13, 0);
        push_desc(32'h14, 1);
        exp_record(0, 1'b0, 32'h11);
        exp_record(1, 1'b0, 32'h12);
        exp_record(0, 1'b0, 32'h13);
        exp_record(1, 1'b0, 32'h14);
        wait_drain(200);
        tick(2);
        check("t1_pulls", 64'(pulls - p0), 4);
        check("t1_busy", 64'(busy_o), 0);

        // Simultaneous done on both engines, engine 1 reports an error.
        delay[0]  = 11;
        delay[1]  = 10;
        st_cfg[1] = 1'b1;
        n0 = pushes;
        push_desc(32'h21, 0);
        push_desc(32'h22, 1);
        exp_record(0, 1'b0, 32'h21);
        exp_record(1, 1'b1, 32'h22);
        wait_drain(200);
        tick(2);
        check("t2_back_to_back", 64'(push_cyc[n0 + 1] - push_cyc[n0]), 1);
        delay[0]  = 10;
        st_cfg[1] = 1'b0;

        // Completion writer stalled with both engines pending.
        complete_ready_i = 1'b0;
        p0 = pulls;
        n0 = pushes;
        push_desc(32'h31, 0);
        push_desc(32'h32, 1);
        push_desc(32'h33, 0);
        exp_record(0, 1'b0, 32'h31);
        exp_record(1, 1'b0, 32'h32);
        exp_record(0, 1'b0, 32'h33);
        tick(35);
        check("t3_no_push", 64'(pushes - n0), 0);
        check("t3_pulls_held", 64'(pulls - p0), 2);
        check("t3_busy", 64'(busy_o), 1);
        complete_ready_i = 1'b1;
        wait_drain(200);
        tick(2);
        check("t3_back_to_back", 64'(push_cyc[n0 + 1] - push_cyc[n0]), 1);

        // Enable drops right after the first dispatch.
        enable_i = 1'b0;
        push_desc(32'h41, 1);
        push_desc(32'h42, -1);
        push_desc(32'h43, -1);
        exp_record(1, 1'b0, 32'h41);
        tick(2);
        p0 = pulls;
        enable_i = 1'b1;
        left = 20;
        do begin
            @(negedge clk);
            left--;
        end while (!dsc_pull_o && left > 0);
        check("t4_pull_seen", 64'(dsc_pull_o), 1);
        @(posedge clk);
        #1;
        enable_i = 1'b0;
        wait_drain(100);
        tick(5);
        check("t4_pulls", 64'(pulls - p0), 1);
        check("t4_busy", 64'(busy_o), 0);
        fifo.delete();
        tick(2);

        // Done pulse on idle engine 1.
        check("t5_spurious_pre", 64'(spurious_o), 0);
        n0 = pushes;
        inject = 2'b10;
        tick(3);
        check("t5_spurious_set", 64'(spurious_o), 1);
        tick(10);
        check("t5_spurious_sticky", 64'(spurious_o), 1);
        check("t5_no_record", 64'(pushes - n0), 0);
        check("t5_busy", 64'(busy_o), 0);

        // Reset while both engines run.
        delay[0] = 50;
        delay[1] = 50;
        enable_i = 1'b1;
        n0 = pushes;
        push_desc(32'h61, 0);
        push_desc(32'h62, 1);
        wait_drain(20);
        tick(2);
        check("t6_busy_run", 64'(busy_o), 1);
        rst = 1'b1;
        tick(1);
        check_zero("t6_rst");
        tick(1);
        rst = 1'b0;
        delay[0] = 10;
        delay[1] = 10;
        tick(1);
        push_desc(32'h71, 0);
        exp_record(0, 1'b0, 32'h71);
        wait_drain(100);
        tick(2);
        check("t6_records_after_reset", 64'(pushes - n0), 1);

        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
